// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {DWELL, SAMPLE, COMMIT} scan_state_t;

    localparam int DEB_W = 4;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Synchronous event queue with valid/ready head and a sticky drop flag.
module keypad_event_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] head_data,
    input  logic              ovf_clr,
    output logic              overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_q, rd_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              full, pop, wr_en, drop;

    // Extra pointer bit separates full from empty when the indices match.
    assign valid = (wr_q != rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = valid && ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign head_data = valid ? mem[rd_q[AW-1:0]] : '0;

    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_q[AW-1:0]] <= push_data;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_q     <= '0;
            rd_q     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Row-strobed matrix scanner: dwell, sample columns, then debounce one key
// per cycle and queue press/release events in scan order.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 6,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [COLS-1:0]               keycol,
    output logic [ROWS-1:0]               keyrow,
    output logic [ROWS*COLS-1:0]          button,
    output logic                          event_valid,
    input  logic                          event_ready,
    output logic [$clog2(ROWS*COLS)-1:0]  event_code,
    output logic                          event_press,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int NKEYS = ROWS * COLS;
    localparam int KW    = idx_w(NKEYS);
    localparam int RW    = idx_w(ROWS);
    localparam int CW    = idx_w(COLS);
    localparam int DW    = idx_w(SCAN_DIV);

    typedef struct packed {
        logic [KW-1:0] code;
        logic          press;
    } key_event_t;

    scan_state_t                  state_q, state_d;
    logic [DW-1:0]                dwell_q;
    logic [RW-1:0]                row_q;
    logic [CW-1:0]                col_q;
    logic [COLS-1:0]              sample_q;
    logic [NKEYS-1:0]             button_q;
    logic [NKEYS-1:0][DEB_W-1:0]  cnt_q;
    logic                         dwell_done, last_col, commit, disagree, flip;
    logic [KW-1:0]                key;
    key_event_t                   push_evt, head_evt;

    assign dwell_done = (dwell_q == DW'(SCAN_DIV - 1));
    assign last_col   = (col_q == CW'(COLS - 1));
    assign key        = KW'(row_q) * KW'(COLS) + KW'(col_q);
    assign disagree   = (sample_q[col_q] != button_q[key]);
    assign flip       = commit && disagree && (cnt_q[key] == DEB_W'(DEBOUNCE - 1));

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        unique case (state_q)
            DWELL:   if (dwell_done) state_d = SAMPLE;
            SAMPLE:  state_d = COMMIT;
            COMMIT: begin
                commit = 1'b1;
                if (last_col) state_d = DWELL;
            end
            default: state_d = DWELL;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= DWELL;
            dwell_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            sample_q <= '0;
            button_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DWELL)  dwell_q  <= dwell_done ? '0 : dwell_q + 1'b1;
            if (state_q == SAMPLE) sample_q <= ~keycol;
            if (commit) begin
                col_q <= last_col ? '0 : col_q + 1'b1;
                if (last_col) row_q <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
                // An agreeing sample is a bounce and restarts the run.
                if (!disagree || flip) cnt_q[key] <= '0;
                else                   cnt_q[key] <= cnt_q[key] + 1'b1;
                if (flip) button_q[key] <= ~button_q[key];
            end
        end
    end

    assign keyrow = ~(ROWS'(1) << row_q);
    assign button = button_q;

    assign push_evt.code  = key;
    assign push_evt.press = ~button_q[key];

    keypad_event_fifo #(
        .DATA_W ($bits(key_event_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (flip),
        .push_data (push_evt),
        .valid     (event_valid),
        .ready     (event_ready),
        .head_data (head_evt),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow)
    );

    assign event_code  = head_evt.code;
    assign event_press = head_evt.press;

endmodule
